// File: rtl/ldst_control_sequencer_pkg.sv
// Shared definitions for the load/store control sequencer: state encodings, opcode constants,
// strobe-vector bit positions and the per-state strobe decode.
package ldst_control_sequencer_pkg;

  localparam int OPCODE_WIDTH = 5;
  localparam int ALU_OP_WIDTH = 5;

  localparam logic [OPCODE_WIDTH-1:0] OP_LD  = 5'b00000;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = 5'b00001;
  localparam logic [OPCODE_WIDTH-1:0] OP_ST  = 5'b00010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 5'b00011;

  typedef enum logic [4:0] {
    S_IDLE  = 5'd0,
    S_T0    = 5'd1,
    S_T1    = 5'd2,
    S_W1    = 5'd3,
    S_T2    = 5'd4,
    S_DEC   = 5'd5,
    S_T3    = 5'd6,
    S_T4    = 5'd7,
    S_T5    = 5'd8,
    S_T6    = 5'd9,
    S_W2    = 5'd10,
    S_T7    = 5'd11,
    S_W3    = 5'd12,
    S_END   = 5'd13,
    S_FAULT = 5'd14
  } state_e;

  localparam int SB_PCOUT   = 0;
  localparam int SB_INCPC   = 1;
  localparam int SB_PCIN    = 2;
  localparam int SB_MARIN   = 3;
  localparam int SB_MDRIN   = 4;
  localparam int SB_MDROUT  = 5;
  localparam int SB_IRIN    = 6;
  localparam int SB_YIN     = 7;
  localparam int SB_ZIN     = 8;
  localparam int SB_ZLOOUT  = 9;
  localparam int SB_COUT    = 10;
  localparam int SB_GRA     = 11;
  localparam int SB_GRB     = 12;
  localparam int SB_RIN     = 13;
  localparam int SB_ROUT    = 14;
  localparam int SB_BAOUT   = 15;
  localparam int SB_MEMREAD = 16;
  localparam int SB_MEMWRITE = 17;
  localparam int SB_MEMEN   = 18;
  localparam int NUM_STROBES = 19;

  typedef logic [NUM_STROBES-1:0] strobe_t;

  function automatic logic isLdst(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  endfunction

  // Strobes asserted while sitting in a state; op is the captured opcode for execute states.
  function automatic strobe_t strobesFor(input state_e st, input logic [OPCODE_WIDTH-1:0] op);
    strobe_t s;
    s = '0;
    case (st)
      S_T0: begin
        s[SB_PCOUT] = 1'b1; s[SB_MARIN] = 1'b1; s[SB_INCPC] = 1'b1; s[SB_ZIN] = 1'b1;
      end
      S_T1: begin
        s[SB_ZLOOUT] = 1'b1; s[SB_PCIN] = 1'b1;
        s[SB_MEMREAD] = 1'b1; s[SB_MEMEN] = 1'b1; s[SB_MDRIN] = 1'b1;
      end
      S_W1: begin
        s[SB_MEMREAD] = 1'b1; s[SB_MEMEN] = 1'b1; s[SB_MDRIN] = 1'b1;
      end
      S_T2: begin
        s[SB_MDROUT] = 1'b1; s[SB_IRIN] = 1'b1;
      end
      S_T3: begin
        s[SB_GRB] = 1'b1; s[SB_BAOUT] = 1'b1; s[SB_YIN] = 1'b1;
      end
      S_T4: begin
        s[SB_COUT] = 1'b1; s[SB_ZIN] = 1'b1;
      end
      S_T5: begin
        s[SB_ZLOOUT] = 1'b1;
        if (op == OP_LDI) begin
          s[SB_GRA] = 1'b1; s[SB_RIN] = 1'b1;
        end else begin
          s[SB_MARIN] = 1'b1;
        end
      end
      S_T6, S_W2: begin
        s[SB_MDRIN] = 1'b1;
        if (op == OP_ST) begin
          s[SB_GRA] = 1'b1; s[SB_ROUT] = 1'b1;
        end else begin
          s[SB_MEMREAD] = 1'b1; s[SB_MEMEN] = 1'b1;
        end
      end
      S_T7, S_W3: begin
        if (op == OP_ST) begin
          s[SB_MEMWRITE] = 1'b1; s[SB_MEMEN] = 1'b1;
        end else begin
          s[SB_MDROUT] = 1'b1; s[SB_GRA] = 1'b1; s[SB_RIN] = 1'b1;
        end
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ldst_control_sequencer_mem_wait_timer.sv
// Counts consecutive memory-wait cycles and flags the cycle on which the count reaches
// MEM_WAIT_MAX; only instantiated when MEM_TIMEOUT_EN is defined.
module ldst_control_sequencer_mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_wait_i,
  output logic expired_o
);

  localparam int CountWidth = $clog2(MEM_WAIT_MAX + 1);

  logic [CountWidth-1:0] count_q, count_d;

  // Outside a wait the counter sits at zero, so every wait state starts counting fresh.
  always_comb begin
    count_d = count_q;
    if (!in_wait_i) begin
      count_d = '0;
    end else if (count_q != CountWidth'(MEM_WAIT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = in_wait_i && (count_q == CountWidth'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/ldst_control_sequencer.sv
// Hardwired fetch + ld/ldi/st control sequencer with registered Moore strobes.
// Optional memory-wait timeout (FAULT state, mem_timeout_o) is enabled by defining MEM_TIMEOUT_EN.
module ldst_control_sequencer
  import ldst_control_sequencer_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                    clk_i,
  input  logic                    clear_ni,
  input  logic                    run_i,
  input  logic [OPCODE_WIDTH-1:0] ir_opcode_i,
  input  logic                    memory_done_i,
  output logic                    PCout_o,
  output logic                    IncPC_o,
  output logic                    PCin_o,
  output logic                    MARin_o,
  output logic                    MDRin_o,
  output logic                    MDRout_o,
  output logic                    IRin_o,
  output logic                    Yin_o,
  output logic                    Zin_o,
  output logic                    Zlo_out_o,
  output logic                    Cout_o,
  output logic                    Gra_o,
  output logic                    Grb_o,
  output logic                    Rin_o,
  output logic                    Rout_o,
  output logic                    BAout_o,
  output logic                    Mem_Read_o,
  output logic                    Mem_Write_o,
  output logic                    Mem_enable512x32_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic                    busy_o,
  output logic                    illegal_op_o,
  output logic                    mem_timeout_o,
  output logic [4:0]              state_dbg_o
);

  state_e                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  strobe_t                 strobe_q;
  logic [ALU_OP_WIDTH-1:0] alu_q;
  logic                    busy_q;
  logic                    illegal_q, illegal_d;
  logic                    timeout_q, timeout_d;
  logic                    inWait;
  logic                    waitExpired;

  assign inWait = (state_q == S_W1) || (state_q == S_W2) || (state_q == S_W3);

`ifdef MEM_TIMEOUT_EN
  ldst_control_sequencer_mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_ni    (clear_ni),
    .in_wait_i (inWait),
    .expired_o (waitExpired)
  );
`else
  logic unusedWaitCfg;
  assign unusedWaitCfg = inWait & (MEM_WAIT_MAX > 0);
  assign waitExpired   = 1'b0;
`endif

  // A completing access wins over an expiring wait on the same cycle.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: if (run_i) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_W1;
      S_W1: begin
        if (memory_done_i) begin
          state_d = S_T2;
        end else if (waitExpired) begin
          state_d   = S_FAULT;
          timeout_d = 1'b1;
        end
      end
      S_T2:   state_d = S_DEC;
      S_DEC: begin
        opcode_d = ir_opcode_i;
        if (isLdst(ir_opcode_i)) begin
          state_d = S_T3;
        end else begin
          illegal_d = 1'b1;
          state_d   = run_i ? S_T0 : S_IDLE;
        end
      end
      S_T3:   state_d = S_T4;
      S_T4:   state_d = S_T5;
      S_T5:   state_d = (opcode_q == OP_LDI) ? S_END : S_T6;
      S_T6:   state_d = (opcode_q == OP_LD) ? S_W2 : S_T7;
      S_W2: begin
        if (memory_done_i) begin
          state_d = S_T7;
        end else if (waitExpired) begin
          state_d   = S_FAULT;
          timeout_d = 1'b1;
        end
      end
      S_T7:   state_d = (opcode_q == OP_LD) ? S_END : S_W3;
      S_W3: begin
        if (memory_done_i) begin
          state_d = S_END;
        end else if (waitExpired) begin
          state_d   = S_FAULT;
          timeout_d = 1'b1;
        end
      end
      S_END:   state_d = run_i ? S_T0 : S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk_i or negedge clear_ni) begin
    if (!clear_ni) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      strobe_q  <= '0;
      alu_q     <= '0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      strobe_q  <= strobesFor(state_d, opcode_d);
      alu_q     <= (state_d == S_T4) ? ALU_ADD : '0;
      busy_q    <= (state_d != S_IDLE) && (state_d != S_FAULT);
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign PCout_o            = strobe_q[SB_PCOUT];
  assign IncPC_o            = strobe_q[SB_INCPC];
  assign PCin_o             = strobe_q[SB_PCIN];
  assign MARin_o            = strobe_q[SB_MARIN];
  assign MDRin_o            = strobe_q[SB_MDRIN];
  assign MDRout_o           = strobe_q[SB_MDROUT];
  assign IRin_o             = strobe_q[SB_IRIN];
  assign Yin_o              = strobe_q[SB_YIN];
  assign Zin_o              = strobe_q[SB_ZIN];
  assign Zlo_out_o          = strobe_q[SB_ZLOOUT];
  assign Cout_o             = strobe_q[SB_COUT];
  assign Gra_o              = strobe_q[SB_GRA];
  assign Grb_o              = strobe_q[SB_GRB];
  assign Rin_o              = strobe_q[SB_RIN];
  assign Rout_o             = strobe_q[SB_ROUT];
  assign BAout_o            = strobe_q[SB_BAOUT];
  assign Mem_Read_o         = strobe_q[SB_MEMREAD];
  assign Mem_Write_o        = strobe_q[SB_MEMWRITE];
  assign Mem_enable512x32_o = strobe_q[SB_MEMEN];
  assign alu_op_o           = alu_q;
  assign busy_o             = busy_q;
  assign illegal_op_o       = illegal_q;
  assign mem_timeout_o      = timeout_q;
  assign state_dbg_o        = state_q;

endmodule
